// File: rtl/calc_pkg.sv
// Shared types and defaults for the shift-add scaling unit.
package calc_pkg;

    localparam int unsigned CALC_WIDTH_DEF = 32;
    localparam int unsigned CALC_COEFF_DEF = 100;

    // Control FSM: one request per IDLE -> RUN -> DONE pass.
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } calc_state_e;

endpackage

// File: rtl/calc_shift_add.sv
// Iterative shift-add multiplier datapath: one multiplier bit per step.
module calc_shift_add #(
    parameter int unsigned WIDTH = 32
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               load_i,
    input  logic               step_i,
    input  logic [WIDTH-1:0]   mcand_i,
    input  logic [WIDTH-1:0]   mult_i,
    output logic [2*WIDTH-1:0] product_next_o,
    output logic               last_o
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);

    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mult_q, mult_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_sum;

    // Partial sum including the current step; on the final step this is the full product.
    always_comb begin
        acc_sum = acc_q + (mult_q[0] ? mcand_q : '0);
    end

    // Next-state: load clears the accumulator, each step consumes one multiplier bit.
    always_comb begin
        acc_d   = acc_q;
        mcand_d = mcand_q;
        mult_d  = mult_q;
        cnt_d   = cnt_q;
        if (load_i) begin
            acc_d   = '0;
            mcand_d = {{WIDTH{1'b0}}, mcand_i};
            mult_d  = mult_i;
            cnt_d   = '0;
        end else if (step_i) begin
            acc_d   = acc_sum;
            mcand_d = mcand_q << 1;
            mult_d  = mult_q >> 1;
            cnt_d   = cnt_q + 1'b1;
        end
    end

    // Datapath registers with asynchronous clear.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_q   <= '0;
            mcand_q <= '0;
            mult_q  <= '0;
            cnt_q   <= '0;
        end else begin
            acc_q   <= acc_d;
            mcand_q <= mcand_d;
            mult_q  <= mult_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs: product as of the current step, and a flag marking the final step.
    always_comb begin
        product_next_o = acc_sum;
        last_o         = (cnt_q == CntW'(WIDTH - 1));
    end

endmodule

// File: rtl/calculate_scale.sv
// Fixed-latency unsigned scaler: a*COEFF or a*b via a shift-add datapath.
module calculate_scale
    import calc_pkg::*;
#(
    parameter int unsigned WIDTH    = CALC_WIDTH_DEF,
    parameter int unsigned COEFF    = CALC_COEFF_DEF,
    parameter int unsigned SATURATE = 0
) (
    input  logic             ap_clk,
    input  logic             ap_rst_n,
    input  logic             ap_start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ap_done,
    output logic             ap_idle,
    output logic             ap_ready,
    output logic [WIDTH-1:0] ap_return,
    output logic             ap_ovf
);

    calc_state_e        state_q, state_d;
    logic [WIDTH-1:0]   ret_q, ret_d;
    logic               ovf_q, ovf_d;
    logic               load;
    logic               step;
    logic               last;
    logic [WIDTH-1:0]   mult_sel;
    logic [2*WIDTH-1:0] product;
    logic               prod_ovf;

    calc_shift_add #(
        .WIDTH (WIDTH)
    ) u_shift_add (
        .clk_i          (ap_clk),
        .rst_ni         (ap_rst_n),
        .load_i         (load),
        .step_i         (step),
        .mcand_i        (a),
        .mult_i         (mult_sel),
        .product_next_o (product),
        .last_o         (last)
    );

    // Operand capture happens only on the IDLE -> RUN transition.
    always_comb begin
        load     = (state_q == StIdle) && ap_start;
        step     = (state_q == StRun);
        mult_sel = op ? b : WIDTH'(COEFF);
    end

    // FSM next-state: RUN lasts exactly WIDTH cycles, DONE lasts one.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (ap_start) state_d = StRun;
            StRun:   if (last) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Result formatting, latched on the edge entering DONE.
    always_comb begin
        prod_ovf = |product[2*WIDTH-1:WIDTH];
        ret_d    = ret_q;
        ovf_d    = ovf_q;
        if (step && last) begin
            ovf_d = prod_ovf;
            if ((SATURATE != 0) && prod_ovf) begin
                ret_d = '1;
            end else begin
                ret_d = product[WIDTH-1:0];
            end
        end
    end

    // Control and result registers with asynchronous clear.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q <= StIdle;
            ret_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ret_q   <= ret_d;
            ovf_q   <= ovf_d;
        end
    end

    // Handshake outputs decoded from state.
    always_comb begin
        ap_done   = (state_q == StDone);
        ap_ready  = (state_q == StDone);
        ap_idle   = (state_q == StIdle);
        ap_return = ret_q;
        ap_ovf    = ovf_q;
    end

endmodule

// File: tb/tb_calculate_scale.sv
// Directed bench: three instances (32-bit truncating, 32-bit saturating, 8-bit).
module tb_calculate_scale;

    logic        ap_clk;
    logic        ap_rst_n;

    logic        start0, op0;
    logic [31:0] a0, b0;
    logic        done0, idle0, ready0, ovf0;
    logic [31:0] ret0;

    logic        done1, idle1, ready1, ovf1;
    logic [31:0] ret1;

    logic        start2, op2;
    logic [7:0]  a2, b2;
    logic        done2, idle2, ready2, ovf2;
    logic [7:0]  ret2;

    int n_cmp;
    int n_err;

    calculate_scale #(.WIDTH(32), .COEFF(100), .SATURATE(0)) dut0 (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ap_start(start0), .op(op0), .a(a0), .b(b0),
        .ap_done(done0), .ap_idle(idle0), .ap_ready(ready0), .ap_return(ret0), .ap_ovf(ovf0)
    );

    calculate_scale #(.WIDTH(32), .COEFF(100), .SATURATE(1)) dut1 (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ap_start(start0), .op(op0), .a(a0), .b(b0),
        .ap_done(done1), .ap_idle(idle1), .ap_ready(ready1), .ap_return(ret1), .ap_ovf(ovf1)
    );

    calculate_scale #(.WIDTH(8), .COEFF(100), .SATURATE(0)) dut2 (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ap_start(start2), .op(op2), .a(a2), .b(b2),
        .ap_done(done2), .ap_idle(idle2), .ap_ready(ready2), .ap_return(ret2), .ap_ovf(ovf2)
    );

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    // Counts rising edges until the selected instance shows ap_done (bounded).
    task automatic wait_done(input int which, output int cyc);
        bit seen;
        seen = 1'b0;
        cyc  = 0;
        while (!seen && cyc < 200) begin
            @(posedge ap_clk);
            #1;
            cyc++;
            if (which == 2) seen = done2;
            else            seen = done0;
        end
        if (!seen) cyc = 999;
    endtask

    task automatic test_reset();
        start0 = 0; op0 = 0; a0 = 0; b0 = 0;
        start2 = 0; op2 = 0; a2 = 0; b2 = 0;
        ap_rst_n = 0;
        #1;
        n_cmp++; if (idle0 !== 1'b1) begin n_err++; $display("FAIL reset_idle0 got %b want 1", idle0); end
        n_cmp++; if (done0 !== 1'b0) begin n_err++; $display("FAIL reset_done0 got %b want 0", done0); end
        n_cmp++; if (ready0 !== 1'b0) begin n_err++; $display("FAIL reset_ready0 got %b want 0", ready0); end
        n_cmp++; if (ret0 !== 32'd0) begin n_err++; $display("FAIL reset_ret0 got %0d want 0", ret0); end
        n_cmp++; if (ovf0 !== 1'b0) begin n_err++; $display("FAIL reset_ovf0 got %b want 0", ovf0); end
        n_cmp++; if (idle2 !== 1'b1) begin n_err++; $display("FAIL reset_idle2 got %b want 1", idle2); end
        repeat (2) @(posedge ap_clk);
        @(negedge ap_clk);
        ap_rst_n = 1;
        @(negedge ap_clk);
    endtask

    task automatic test_coeff();
        int cyc;
        a0 = 32'd5; op0 = 0; start0 = 1;
        wait_done(0, cyc);
        start0 = 0;
        n_cmp++; if (cyc !== 33) begin n_err++; $display("FAIL coeff_latency got %0d want 33", cyc); end
        n_cmp++; if (ret0 !== 32'd500) begin n_err++; $display("FAIL coeff_ret got %0d want 500", ret0); end
        n_cmp++; if (ovf0 !== 1'b0) begin n_err++; $display("FAIL coeff_ovf got %b want 0", ovf0); end
        n_cmp++; if (ready0 !== 1'b1) begin n_err++; $display("FAIL coeff_ready got %b want 1", ready0); end
        @(posedge ap_clk); #1;
        n_cmp++; if (done0 !== 1'b0) begin n_err++; $display("FAIL coeff_done_pulse got %b want 0", done0); end
        n_cmp++; if (idle0 !== 1'b1) begin n_err++; $display("FAIL coeff_idle_after got %b want 1", idle0); end
        n_cmp++; if (ret0 !== 32'd500) begin n_err++; $display("FAIL coeff_ret_hold got %0d want 500", ret0); end
        @(negedge ap_clk);
    endtask

    task automatic test_saturate();
        int cyc;
        a0 = 32'hFFFF_FFFF; b0 = 32'd2; op0 = 1; start0 = 1;
        wait_done(0, cyc);
        start0 = 0;
        n_cmp++; if (ret0 !== 32'hFFFF_FFFE) begin n_err++; $display("FAIL trunc_ret got %h want fffffffe", ret0); end
        n_cmp++; if (ovf0 !== 1'b1) begin n_err++; $display("FAIL trunc_ovf got %b want 1", ovf0); end
        n_cmp++; if (done1 !== 1'b1) begin n_err++; $display("FAIL sat_done got %b want 1", done1); end
        n_cmp++; if (ret1 !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL sat_ret got %h want ffffffff", ret1); end
        n_cmp++; if (ovf1 !== 1'b1) begin n_err++; $display("FAIL sat_ovf got %b want 1", ovf1); end
        @(negedge ap_clk);
        @(negedge ap_clk);
    endtask

    task automatic test_narrow();
        int cyc;
        a2 = 8'd3; op2 = 0; start2 = 1;
        wait_done(2, cyc);
        start2 = 0;
        n_cmp++; if (cyc !== 9) begin n_err++; $display("FAIL narrow_latency got %0d want 9", cyc); end
        n_cmp++; if (ret2 !== 8'd44) begin n_err++; $display("FAIL narrow_ret got %0d want 44", ret2); end
        n_cmp++; if (ovf2 !== 1'b1) begin n_err++; $display("FAIL narrow_ovf got %b want 1", ovf2); end
        n_cmp++; if (ready2 !== 1'b1) begin n_err++; $display("FAIL narrow_ready got %b want 1", ready2); end
        @(negedge ap_clk);
        @(negedge ap_clk);
    endtask

    task automatic test_zero();
        int cyc;
        a0 = 32'd0; b0 = 32'd12345; op0 = 1; start0 = 1;
        wait_done(0, cyc);
        start0 = 0;
        n_cmp++; if (cyc !== 33) begin n_err++; $display("FAIL zero_a_latency got %0d want 33", cyc); end
        n_cmp++; if (ret0 !== 32'd0) begin n_err++; $display("FAIL zero_a_ret got %0d want 0", ret0); end
        n_cmp++; if (ovf0 !== 1'b0) begin n_err++; $display("FAIL zero_a_ovf got %b want 0", ovf0); end
        @(negedge ap_clk);
        @(negedge ap_clk);
        a0 = 32'd1234; b0 = 32'd0; op0 = 1; start0 = 1;
        wait_done(0, cyc);
        start0 = 0;
        n_cmp++; if (ret0 !== 32'd0) begin n_err++; $display("FAIL zero_b_ret got %0d want 0", ret0); end
        n_cmp++; if (ovf0 !== 1'b0) begin n_err++; $display("FAIL zero_b_ovf got %b want 0", ovf0); end
        @(negedge ap_clk);
        @(negedge ap_clk);
    endtask

    task automatic test_back_to_back();
        int cyc;
        a0 = 32'd7; op0 = 0; start0 = 1;
        wait_done(0, cyc);
        n_cmp++; if (ret0 !== 32'd700) begin n_err++; $display("FAIL b2b_first_ret got %0d want 700", ret0); end
        a0 = 32'd9;
        @(posedge ap_clk); #1;
        n_cmp++; if (idle0 !== 1'b1) begin n_err++; $display("FAIL b2b_idle_gap got %b want 1", idle0); end
        wait_done(0, cyc);
        start0 = 0;
        // One edge already spent in the gap, so 34 total between pulses.
        n_cmp++; if (cyc + 1 !== 34) begin n_err++; $display("FAIL b2b_spacing got %0d want 34", cyc + 1); end
        n_cmp++; if (ret0 !== 32'd900) begin n_err++; $display("FAIL b2b_second_ret got %0d want 900", ret0); end
        @(negedge ap_clk);
        @(negedge ap_clk);
    endtask

    task automatic test_ignore_inputs();
        int cyc;
        a0 = 32'd5; op0 = 0; b0 = 32'd3; start0 = 1;
        @(posedge ap_clk); #1;
        a0 = 32'd1000; op0 = 1;
        wait_done(0, cyc);
        start0 = 0;
        n_cmp++; if (ret0 !== 32'd500) begin n_err++; $display("FAIL ignore_ret got %0d want 500", ret0); end
        n_cmp++; if (cyc + 1 !== 33) begin n_err++; $display("FAIL ignore_latency got %0d want 33", cyc + 1); end
        @(negedge ap_clk);
        @(negedge ap_clk);
    endtask

    task automatic test_reset_mid_run();
        int cyc;
        bit stray;
        a0 = 32'd5; op0 = 0; start0 = 1;
        repeat (10) @(posedge ap_clk);
        #1;
        n_cmp++; if (idle0 !== 1'b0) begin n_err++; $display("FAIL midrst_busy got %b want 0", idle0); end
        start0 = 0;
        ap_rst_n = 0;
        #1;
        n_cmp++; if (idle0 !== 1'b1) begin n_err++; $display("FAIL midrst_idle got %b want 1", idle0); end
        n_cmp++; if (ret0 !== 32'd0) begin n_err++; $display("FAIL midrst_ret got %0d want 0", ret0); end
        repeat (2) @(posedge ap_clk);
        @(negedge ap_clk);
        ap_rst_n = 1;
        stray = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge ap_clk); #1;
            if (done0 === 1'b1) stray = 1'b1;
        end
        n_cmp++; if (stray !== 1'b0) begin n_err++; $display("FAIL midrst_no_done got %b want 0", stray); end
        @(negedge ap_clk);
        a0 = 32'd2; op0 = 0; start0 = 1;
        wait_done(0, cyc);
        start0 = 0;
        n_cmp++; if (cyc !== 33) begin n_err++; $display("FAIL restart_latency got %0d want 33", cyc); end
        n_cmp++; if (ret0 !== 32'd200) begin n_err++; $display("FAIL restart_ret got %0d want 200", ret0); end
        @(negedge ap_clk);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_coeff();
        test_saturate();
        test_narrow();
        test_zero();
        test_back_to_back();
        test_ignore_inputs();
        test_reset_mid_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/calculate_scale.md
CALCULATE_SCALE -- requirements
Module: calculate_scale

Interface
REQ-001 Parameter WIDTH, default 32, operand and result width in bits (>= 4).
REQ-002 Parameter COEFF, default 100, constant multiplier used when op=0; SHALL fit in WIDTH bits.
REQ-003 Parameter SATURATE, default 0, 1 = clamp overflowing results to all-ones, 0 = truncate.
REQ-004 ap_clk  in  1  sole clock, all state on rising edge.
REQ-005 ap_rst_n  in  1  reset, asynchronous, active-low.
REQ-006 ap_start  in  1  request; held high until ap_ready.
REQ-007 op  in  1  0 = a*COEFF, 1 = a*b.
REQ-008 a  in  WIDTH  unsigned multiplicand.
REQ-009 b  in  WIDTH  unsigned multiplier, used only when op=1.
REQ-010 ap_done  out  1  one-cycle pulse, result valid.
REQ-011 ap_idle  out  1  high while no operation in progress.
REQ-012 ap_ready  out  1  one-cycle pulse coincident with ap_done.
REQ-013 ap_return  out  WIDTH  registered result, held until next ap_done.
REQ-014 ap_ovf  out  1  registered overflow flag, updated with ap_return.

Function
REQ-015 FSM states IDLE, RUN, DONE; IDLE -> RUN when ap_start=1, RUN -> DONE after exactly WIDTH RUN cycles, DONE -> IDLE unconditionally.
REQ-016 On IDLE->RUN the block SHALL capture a, multiplier (op ? b : COEFF), clear 2*WIDTH-bit accumulator and bit counter.
REQ-017 Each RUN cycle: if multiplier LSB=1, accumulator += shifted multiplicand; multiplicand shifts left 1, multiplier shifts right 1, counter increments.
REQ-018 Latency fixed: ap_start sampled in IDLE at cycle 0 -> ap_done=1 in cycle WIDTH+1, independent of operand values.
REQ-019 ap_done and ap_ready SHALL be high only in DONE; ap_idle SHALL be high only in IDLE.
REQ-020 ap_return/ap_ovf SHALL update on the edge entering DONE and hold until the next DONE.
REQ-021 ap_ovf = 1 iff upper WIDTH bits of the full product are nonzero.
REQ-022 SATURATE=0: ap_return = low WIDTH bits of product; SATURATE=1 and ap_ovf=1: ap_return = all-ones.
REQ-023 Changes on a, b, op, ap_start during RUN/DONE SHALL be ignored; a started operation always completes.
REQ-024 ap_start still high after DONE SHALL start a new operation from IDLE (one IDLE cycle between operations, ap_idle=1 that cycle).
REQ-025 Zero operands SHALL yield ap_return=0, ap_ovf=0 at normal latency.

Reset
REQ-026 ap_rst_n low SHALL force, asynchronously: state IDLE, ap_return=0, ap_ovf=0, ap_done=0, ap_ready=0, ap_idle=1, accumulator and counter 0.
REQ-027 Reset mid-RUN SHALL discard the operation; no ap_done is produced for it.
REQ-028 Release of reset SHALL take effect on the next rising ap_clk; ap_start high then begins an operation that cycle.

Structure
REQ-029 Shared package calc_pkg SHALL hold the state enum type and default constants (CALC_WIDTH_DEF=32, CALC_COEFF_DEF=100).
REQ-030 The shift-add datapath (accumulator, shifters, counter) SHALL be sub-module calc_shift_add; FSM, result formatting and handshake stay in calculate_scale.

Verification
REQ-031 WIDTH=32, op=0, a=5, single start -> ap_done in cycle 33, ap_return=500, ap_ovf=0, ap_ready coincident.
REQ-032 WIDTH=32, op=1, a=0xFFFFFFFF, b=2 -> SATURATE=0: ap_return=0xFFFFFFFE, ap_ovf=1; SATURATE=1: 0xFFFFFFFF, ap_ovf=1.
REQ-033 WIDTH=8, COEFF=100, op=0, a=3 -> ap_return=44 (300 mod 256), ap_ovf=1, ap_done in cycle 9.
REQ-034 ap_start held high, a=7 then a=9 (op=0) -> results 700 then 900, ap_done pulses 34 cycles apart, ap_idle=1 one cycle between.
REQ-035 Start a=5, assert ap_rst_n=0 at cycle 10 for 2 cycles -> immediate ap_idle=1, ap_return=0, no ap_done afterwards until a new start.
REQ-036 Start a=5, op=0, then drive a=1000, op=1 during RUN -> ap_return=500.
